// File: rtl/img_buffer_if.sv
// Pixel-stream and window-row handshake bundle between the pixel source, img_buffer and im2col.
interface img_buffer_if #(
    parameter int IMG_W  = 28,
    parameter int K      = 3,
    parameter int DW     = 8,
    parameter int ADDR_W = 5
);
    logic                             pix_valid;
    logic                             pix_ready;
    logic [DW-1:0]                    pix_data;
    logic                             pix_last;
    logic                             post_valid;
    logic                             post_ready;
    logic [ADDR_W-1:0]                addr;
    logic [K-1:0][IMG_W-1:0][DW-1:0]  data;
    logic                             frame_err;

    modport master (
        output pix_valid, pix_data, pix_last, post_ready, addr,
        input  pix_ready, post_valid, data, frame_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_last, post_ready, addr,
        output pix_ready, post_valid, data, frame_err
    );
endinterface

// File: rtl/img_buffer.sv
// Full-frame buffer ahead of im2col: fills one IMG_H x IMG_W image row-major,
// then serves K-row windows addressed by im2col until IMG_H-K+1 handshakes release it.
module img_buffer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int DW     = 8,
    parameter int ADDR_W = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    img_buffer_if.slave img_bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [RW-1:0]     SERVE_LAST = RW'(IMG_H - K);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(IMG_H - K);

    typedef enum logic {FILL, SERVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [RW-1:0] serve_cnt_q, serve_cnt_d;
    logic          frame_err_q, frame_err_d;

    logic          pix_ready;
    logic          post_valid;
    logic          pix_fire;
    logic          post_fire;
    logic          at_final;
    logic [RW-1:0] row_idx;

    logic [DW-1:0] pix_mem [IMG_H][IMG_W];
    logic [K-1:0][IMG_W-1:0][DW-1:0] win;

    assign pix_fire  = img_bus.pix_valid & pix_ready;
    assign post_fire = post_valid & img_bus.post_ready;
    assign at_final  = (row_cnt_q == ROW_LAST) && (col_cnt_q == COL_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FILL;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            serve_cnt_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            serve_cnt_q <= serve_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage is deliberately left out of reset; every location is rewritten before it is served.
    always_ff @(posedge i_clk) begin
        if (pix_fire) begin
            pix_mem[row_cnt_q][col_cnt_q] <= img_bus.pix_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        serve_cnt_d = serve_cnt_q;
        frame_err_d = frame_err_q;
        unique case (state_q)
            FILL: begin
                if (pix_fire) begin
                    if (at_final) begin
                        col_cnt_d = '0;
                        row_cnt_d = '0;
                        state_d   = SERVE;
                        if (!img_bus.pix_last) begin
                            frame_err_d = 1'b1;
                        end
                    end else if (img_bus.pix_last) begin
                        // Early last: drop the partial frame and restart at pixel (0,0).
                        col_cnt_d   = '0;
                        row_cnt_d   = '0;
                        frame_err_d = 1'b1;
                    end else if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                if (post_fire) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = FILL;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        pix_ready  = (state_q == FILL);
        post_valid = (state_q == SERVE);
    end

    // Window rows are read straight out of storage so the address-to-data path has no register.
    always_comb begin
        win     = '0;
        row_idx = '0;
        if (post_valid && (img_bus.addr <= ADDR_MAX)) begin
            for (int r = 0; r < K; r++) begin
                row_idx = RW'(img_bus.addr) + RW'(r);
                for (int c = 0; c < IMG_W; c++) begin
                    win[r][c] = pix_mem[row_idx][CW'(c)];
                end
            end
        end
    end

    assign img_bus.pix_ready  = pix_ready;
    assign img_bus.post_valid = post_valid;
    assign img_bus.data       = win;
    assign img_bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_img_buffer.sv
// Directed bench for img_buffer: fills frames with known pixel patterns and checks
// handshakes, served windows, stalls, out-of-range addresses, framing errors and resets.
module tb_img_buffer;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int DW     = 8;
    localparam int ADDR_W = 5;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWIN   = IMG_H - K + 1;

    typedef logic [K-1:0][IMG_W-1:0][DW-1:0] win_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    img_buffer_if #(.IMG_W(IMG_W), .K(K), .DW(DW), .ADDR_W(ADDR_W)) bus ();

    img_buffer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .ADDR_W(ADDR_W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .img_bus (bus.slave)
    );

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected window for address a: pixel (row,col) of a frame was written as (row*IMG_W+col+off)&0xFF.
    task automatic checkWindow(input string tag, input int a, input int off, input bit zero);
        win_t exp_win;
        exp_win = '0;
        if (!zero) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    exp_win[r][c] = DW'((((a + r) * IMG_W) + c + off) & 'hFF);
                end
            end
        end
        vectors++;
        assert (bus.data === exp_win)
        else begin
            miscompares++;
            $error("[TB] FAIL %s a=%0d observed=%h expected=%h", tag, a, bus.data, exp_win);
        end
    endtask

    // Streams beats 0..n-1; pix_last is raised on last_beat (-1 means never).
    task automatic applyStimulus(input int n, input int last_beat, input bit gaps, input int off);
        for (int i = 0; i < n; i++) begin
            bit fired;
            int tries;
            fired = 1'b0;
            tries = 0;
            bus.pix_data = DW'((i + off) & 'hFF);
            bus.pix_last = (i == last_beat);
            while (!fired && tries < 64) begin
                bus.pix_valid = (gaps && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
                fired = bus.pix_valid && bus.pix_ready;
                stepClock();
                tries++;
            end
            if (!fired) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL pix_timeout beat=%0d observed=not_accepted expected=accepted", i);
                bus.pix_valid = 1'b0;
                bus.pix_last  = 1'b0;
                return;
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic serveRange(input int off, input int first, input int count);
        bus.post_ready = 1'b1;
        for (int a = first; a < first + count; a++) begin
            bus.addr = ADDR_W'(a);
            #1;
            checkWindow("serve_win", a, off, 1'b0);
            stepClock();
        end
        bus.post_ready = 1'b0;
    endtask

    task automatic checkReleased(input string tag);
        checkOutput({tag, "_post_valid"}, 32'(bus.post_valid), 32'd0);
        checkOutput({tag, "_pix_ready"},  32'(bus.pix_ready),  32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.pix_last   = 1'b0;
        bus.post_ready = 1'b0;
        bus.addr       = '0;
        stepClock();
        stepClock();
        checkOutput("rst_pix_ready",  32'(bus.pix_ready),  32'd1);
        checkOutput("rst_post_valid", 32'(bus.post_valid), 32'd0);
        checkOutput("rst_frame_err",  32'(bus.frame_err),  32'd0);
        rst = 1'b0;
        stepClock();

        $display("[TB] gapless frame and full serve");
        applyStimulus(NPIX, NPIX - 1, 1'b0, 0);
        checkOutput("full_pix_ready",  32'(bus.pix_ready),  32'd0);
        checkOutput("full_post_valid", 32'(bus.post_valid), 32'd1);
        bus.addr = '0;
        #1;
        checkOutput("a0_r0_c0",  32'(bus.data[0][0]),  32'h00);
        checkOutput("a0_r2_c27", 32'(bus.data[2][27]), 32'h53);
        serveRange(0, 0, NWIN);
        checkReleased("rel1");
        checkOutput("clean_frame_err", 32'(bus.frame_err), 32'd0);

        $display("[TB] stall in serve and release count");
        applyStimulus(NPIX, NPIX - 1, 1'b0, 0);
        bus.post_ready = 1'b0;
        bus.addr       = ADDR_W'(25);
        for (int s = 0; s < 10; s++) begin
            stepClock();
            checkOutput("stall_post_valid", 32'(bus.post_valid), 32'd1);
        end
        checkOutput("stall_a25_r2_c27", 32'(bus.data[2][27]), 32'h0F);
        serveRange(0, 0, NWIN - 1);
        checkOutput("one_left_post_valid", 32'(bus.post_valid), 32'd1);
        serveRange(0, NWIN - 1, 1);
        checkReleased("rel2");

        $display("[TB] gapped frame and out-of-range address");
        applyStimulus(NPIX, NPIX - 1, 1'b1, 0);
        checkOutput("gap_post_valid", 32'(bus.post_valid), 32'd1);
        bus.addr = ADDR_W'(26);
        #1;
        checkWindow("addr26_zero", 26, 0, 1'b1);
        serveRange(0, 0, NWIN);
        checkReleased("rel3");
        bus.addr = '0;
        #1;
        checkWindow("idle_zero", 0, 0, 1'b1);

        $display("[TB] early last then clean frame");
        applyStimulus(101, 100, 1'b0, 'h10);
        checkOutput("early_frame_err",  32'(bus.frame_err),  32'd1);
        checkOutput("early_pix_ready",  32'(bus.pix_ready),  32'd1);
        checkOutput("early_post_valid", 32'(bus.post_valid), 32'd0);
        applyStimulus(NPIX, NPIX - 1, 1'b0, 'h11);
        checkOutput("after_early_post_valid", 32'(bus.post_valid), 32'd1);
        serveRange('h11, 0, NWIN);
        checkReleased("rel4");
        checkOutput("sticky_frame_err", 32'(bus.frame_err), 32'd1);

        $display("[TB] reset mid-fill and mid-serve");
        applyStimulus(400, -1, 1'b0, 'h20);
        rst = 1'b1;
        stepClock();
        checkOutput("rst_fill_pix_ready",  32'(bus.pix_ready),  32'd1);
        checkOutput("rst_fill_post_valid", 32'(bus.post_valid), 32'd0);
        checkOutput("rst_fill_frame_err",  32'(bus.frame_err),  32'd0);
        rst = 1'b0;
        applyStimulus(NPIX, NPIX - 1, 1'b0, 'h22);
        checkOutput("refill_post_valid", 32'(bus.post_valid), 32'd1);
        serveRange('h22, 0, 10);
        rst = 1'b1;
        stepClock();
        checkOutput("rst_serve_pix_ready",  32'(bus.pix_ready),  32'd1);
        checkOutput("rst_serve_post_valid", 32'(bus.post_valid), 32'd0);
        checkOutput("rst_serve_frame_err",  32'(bus.frame_err),  32'd0);
        rst = 1'b0;
        applyStimulus(NPIX, NPIX - 1, 1'b0, 'h33);
        checkOutput("final_post_valid", 32'(bus.post_valid), 32'd1);
        serveRange('h33, 0, NWIN);
        checkReleased("rel5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
